// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud arithmetic for the TX and RX paths.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   function automatic int clk_per_bit(input int clk_rate, input int baud_rate);
      return clk_rate / baud_rate;
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: pulses tick every CLK_PER_BIT enabled cycles; held at zero when disabled or restarted.
module uart_baud_tick #(
   parameter int CLK_PER_BIT = 217
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic tick
);
   localparam int CW = $clog2(CLK_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
   logic [CW-1:0] cnt;
   assign tick = enable && cnt == LAST;
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= (!enable || restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register for gapless back-to-back frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int CLK_RATE  = 25000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_busy
);
   localparam int CLK_PER_BIT = clk_per_bit(CLK_RATE, BAUD_RATE);
   localparam int BW = $clog2(DATA_BITS) + 1;
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   tx_state_t state;
   logic [DATA_BITS-1:0] hold, shift;
   logic [BW-1:0] bit_cnt;
   logic hold_full, tick, load;
   // Hand the held byte to the shifter from IDLE or on the final stop cycle.
   assign load = hold_full && (state == IDLE || (state == STOP && tick && bit_cnt == LAST_STOP));
   assign tx_ready = !hold_full;
   assign tx_busy = state != IDLE || hold_full;
   uart_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
      .clk(clk),
      .reset(reset),
      .enable(state != IDLE),
      .restart(load),
      .tick(tick)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         tx_serial <= 1'b1;
         hold_full <= 1'b0;
         hold <= '0;
         shift <= '0;
         bit_cnt <= '0;
      end else begin
         tx_serial <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
         if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold <= tx_data;
         end else if (load) hold_full <= 1'b0;
         case (state)
            IDLE: if (load) begin
               shift <= hold;
               state <= START;
            end
            START: if (tick) begin
               bit_cnt <= '0;
               state <= DATA;
            end
            DATA: if (tick) begin
               shift <= shift >> 1;
               bit_cnt <= bit_cnt == LAST_DATA ? '0 : bit_cnt + 1'b1;
               if (bit_cnt == LAST_DATA) state <= STOP;
            end
            STOP: if (tick) begin
               bit_cnt <= bit_cnt == LAST_STOP ? '0 : bit_cnt + 1'b1;
               if (bit_cnt == LAST_STOP) state <= load ? START : IDLE;
               if (load) shift <= hold;
            end
         endcase
      end
   end
endmodule
